mult_div_unit: RTL and testbench

- Iterative multiply/divide unit downstream of the register block.
- Operands come from read_data1/read_data2; results are held in HI/LO registers.
- HI/LO are later moved into the register file via write_data (mfhi/mflo path).
- Handles mult, multu, div, divu with fixed latency and a start/busy/done handshake.

---
 rtl/mult_div_unit_pkg.sv | 31 +++
 rtl/mult_div_unit_twos_negate.sv | 19 +
 rtl/mult_div_unit.sv | 171 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// ============================================================================
// Module      : mult_div_unit_pkg
// Description : Operation and state encodings shared by the multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_div_unit_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FIXUP = 2'd2
    } state_t;

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

`default_nettype wire

// File: rtl/mult_div_unit_twos_negate.sv
// ============================================================================
// Module      : twos_negate
// Description : Combinational two's-complement negation of a WIDTH-bit word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module twos_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_value,
    output logic [WIDTH-1:0] o_value
);

    assign o_value = (~i_value) + WIDTH'(1);

endmodule

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ============================================================================
// Module      : mult_div_unit
// Description : Iterative shift-add multiplier / restoring divider feeding HI/LO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [1:0]          r_op;
    logic                r_neg_res;
    logic                r_neg_rem;
    logic                r_b_zero;
    logic [WIDTH-1:0]    r_a_raw;
    logic [WIDTH-1:0]    r_mag;
    logic [WIDTH-1:0]    r_acc_hi;
    logic [WIDTH-1:0]    r_acc_lo;
    logic                r_busy;
    logic                r_done;
    logic [WIDTH-1:0]    r_hi;
    logic [WIDTH-1:0]    r_lo;

    logic                w_a_neg_sign;
    logic                w_b_neg_sign;
    logic [WIDTH-1:0]    w_a_neg;
    logic [WIDTH-1:0]    w_b_neg;
    logic [WIDTH-1:0]    w_a_mag;
    logic [WIDTH-1:0]    w_b_mag;
    logic [WIDTH:0]      w_mul_sum;
    logic [WIDTH:0]      w_div_shift;
    logic                w_div_ge;
    logic [WIDTH-1:0]    w_div_diff;
    logic [2*WIDTH-1:0]  w_prod_neg;
    logic [WIDTH-1:0]    w_quo_neg;
    logic [WIDTH-1:0]    w_rem_neg;

    // Operand magnitudes: signed ops strip the sign, unsigned ops pass through.
    assign w_a_neg_sign = op_is_signed(op) & operand_a[WIDTH-1];
    assign w_b_neg_sign = op_is_signed(op) & operand_b[WIDTH-1];

    twos_negate #(.WIDTH(WIDTH)) u_neg_a (.i_value(operand_a), .o_value(w_a_neg));
    twos_negate #(.WIDTH(WIDTH)) u_neg_b (.i_value(operand_b), .o_value(w_b_neg));

    assign w_a_mag = w_a_neg_sign ? w_a_neg : operand_a;
    assign w_b_mag = w_b_neg_sign ? w_b_neg : operand_b;

    // Multiply step: conditional add into the upper half with one carry bit.
    assign w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_mag} : '0);

    // Divide step: remainder gains the next dividend bit, then trial subtract.
    assign w_div_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_mag});
    assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_mag;

    twos_negate #(.WIDTH(2*WIDTH)) u_neg_prod (
        .i_value({r_acc_hi, r_acc_lo}),
        .o_value(w_prod_neg)
    );
    twos_negate #(.WIDTH(WIDTH)) u_neg_quo (.i_value(r_acc_lo), .o_value(w_quo_neg));
    twos_negate #(.WIDTH(WIDTH)) u_neg_rem (.i_value(r_acc_hi), .o_value(w_rem_neg));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_op      <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_b_zero  <= 1'b0;
            r_a_raw   <= '0;
            r_mag     <= '0;
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op      <= op;
                        r_neg_res <= w_a_neg_sign ^ w_b_neg_sign;
                        r_neg_rem <= w_a_neg_sign;
                        r_b_zero  <= (operand_b == '0);
                        r_a_raw   <= operand_a;
                        r_cnt     <= '0;
                        r_acc_hi  <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_RUN;
                        // Multiply: a is the addend, b is shifted out of acc_lo.
                        // Divide: a is shifted out of acc_lo, b is the divisor.
                        if (op_is_div(op)) begin
                            r_mag    <= w_b_mag;
                            r_acc_lo <= w_a_mag;
                        end else begin
                            r_mag    <= w_a_mag;
                            r_acc_lo <= w_b_mag;
                        end
                    end
                end

                ST_RUN: begin
                    if (op_is_div(r_op)) begin
                        if (w_div_ge) begin
                            r_acc_hi <= w_div_diff;
                            r_acc_lo <= {r_acc_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            r_acc_hi <= w_div_shift[WIDTH-1:0];
                            r_acc_lo <= {r_acc_lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        r_acc_hi <= w_mul_sum[WIDTH:1];
                        r_acc_lo <= {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
                    end
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH-1)) begin
                        r_state <= ST_FIXUP;
                    end
                end

                ST_FIXUP: begin
                    if (!op_is_div(r_op)) begin
                        {r_hi, r_lo} <= r_neg_res ? w_prod_neg : {r_acc_hi, r_acc_lo};
                    end else if (r_b_zero) begin
                        r_hi <= r_a_raw;
                        r_lo <= '1;
                    end else begin
                        r_lo <= r_neg_res ? w_quo_neg : r_acc_lo;
                        r_hi <= r_neg_rem ? w_rem_neg : r_acc_hi;
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Scoreboard bench for mult_div_unit with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_div_unit;

    localparam logic [1:0] C_MULT  = 2'b00;
    localparam logic [1:0] C_MULTU = 2'b01;
    localparam logic [1:0] C_DIV   = 2'b10;
    localparam logic [1:0] C_DIVU  = 2'b11;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
        string       name;
    } exp_t;

    exp_t sb[$];

    mult_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s: got %h want %h", name, got, want);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_hi"}, 64'(hi), 64'(e.hi));
                check({e.name, "_lo"}, 64'(lo), 64'(e.lo));
                check({e.name, "_latency"}, 64'(cyc), 64'(e.due));
                check({e.name, "_busy_at_done"}, 64'(busy), 64'd0);
            end
        end
    end

    // Called at a negedge; returns just after the edge that samples start.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el,
                         input string name, input bit push);
        start     = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
        @(posedge clk);
        #1;
        if (push) sb.push_back('{eh, el, cyc + 33, name});
        start     = 1'b0;
        operand_a = ~a;
        operand_b = ~b;
    endtask

    task automatic wait_done(input string name, input bit scramble);
        bit got = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                break;
            end
            if (scramble) begin
                operand_a = $urandom;
                operand_b = $urandom;
            end
        end
        if (!got) check({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        reset     = 1'b1;
        start     = 1'b0;
        op        = 2'b00;
        operand_a = '0;
        operand_b = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        issue(C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max", 1);
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy) n++;
            else break;
        end
        check("multu_busy_len", 64'(n), 64'd33);

        issue(C_MULT, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg3x7", 1);
        wait_done("mult_neg3x7", 0);
        issue(C_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7by2", 1);
        wait_done("div_neg7by2", 0);
        issue(C_DIV, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_7byneg2", 1);
        wait_done("div_7byneg2", 0);
        issue(C_DIVU, 32'h0000_1234, 32'h0, 32'h0000_1234, 32'hFFFF_FFFF, "divu_by0", 1);
        wait_done("divu_by0", 0);
        issue(C_DIV, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_by0", 1);
        wait_done("div_by0", 0);
        issue(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, "div_ovf", 1);
        wait_done("div_ovf", 0);

        // Extra start pulses while busy must be dropped.
        issue(C_MULTU, 32'd6, 32'd7, 32'h0, 32'h0000_002A, "multu_6x7", 1);
        for (int i = 1; i < 60; i++) begin
            @(negedge clk);
            if (done) break;
            start     = (i == 5 || i == 20);
            op        = C_DIVU;
            operand_a = 32'd99;
            operand_b = 32'd3;
        end
        start = 1'b0;
        issue(C_DIVU, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, "divu_100by7", 1);
        wait_done("divu_100by7", 0);

        // Reset ten cycles into a multiply aborts it with no done pulse.
        issue(C_MULT, 32'd5, 32'd5, 32'h0, 32'h0, "mult_aborted", 0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_stays_idle", 64'(busy), 64'd0);
        issue(C_MULTU, 32'd2, 32'd3, 32'h0, 32'h0000_0006, "multu_2x3", 1);
        wait_done("multu_2x3", 0);

        issue(C_DIVU, 32'd1000, 32'd10, 32'h0, 32'h0000_0064, "divu_hold", 1);
        wait_done("divu_hold", 1);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
